// File: rtl/reg_dump_engine.sv
// rtl/reg_dump_engine.sv - snapshots PC/instruction and streams the register file as a 34-word frame
module reg_dump_engine #(
    parameter int DUMP_LIMIT = 1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_tag,
    output logic        busy,
    output logic        done,
    output logic        stopped
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_PC,
        SEND_INSTR,
        FETCH,
        SEND_REG,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  reg_sel_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] data_q;
    logic [15:0] frame_cnt;
    logic        accept;

    assign accept = (state == IDLE) && start && !stopped;

    // Outputs are pure functions of registered state, so they cannot move while a word is stalled.
    always_comb begin
        state_nxt   = state;
        reg_sel_nxt = reg_sel;
        out_valid   = 1'b0;
        out_data    = data_q;
        out_tag     = 6'd0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = SEND_PC;
                end
            end
            SEND_PC: begin
                out_valid = 1'b1;
                out_data  = pc_q;
                out_tag   = 6'd0;
                if (out_ready) begin
                    state_nxt = SEND_INSTR;
                end
            end
            SEND_INSTR: begin
                out_valid = 1'b1;
                out_data  = instr_q;
                out_tag   = 6'd1;
                if (out_ready) begin
                    reg_sel_nxt = 5'd0;
                    state_nxt   = FETCH;
                end
            end
            FETCH: begin
                state_nxt = SEND_REG;
            end
            SEND_REG: begin
                out_valid = 1'b1;
                out_tag   = {1'b0, reg_sel} + 6'd2;
                if (out_ready) begin
                    if (reg_sel == 5'd31) begin
                        state_nxt = DONE;
                    end else begin
                        reg_sel_nxt = reg_sel + 5'd1;
                        state_nxt   = FETCH;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            reg_sel   <= 5'd0;
            pc_q      <= 32'd0;
            instr_q   <= 32'd0;
            data_q    <= 32'd0;
            frame_cnt <= 16'd0;
            stopped   <= 1'b0;
        end else begin
            state   <= state_nxt;
            reg_sel <= reg_sel_nxt;
            if (accept) begin
                pc_q    <= pc_in;
                instr_q <= instr_in;
            end
            // x0 is hardwired zero, whatever the register file returns for it.
            if (state == FETCH) begin
                data_q <= (reg_sel == 5'd0) ? 32'd0 : reg_data;
            end
            if (state == DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (frame_cnt + 16'd1 == 16'(DUMP_LIMIT)) begin
                    stopped <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_engine.sv
// tb/tb_reg_dump_engine.sv - randomized self-checking bench for reg_dump_engine
module tb_reg_dump_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_tag;
    logic        busy;
    logic        done;
    logic        stopped;

    logic [31:0] rf [32];
    logic        force_ones;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign reg_data = force_ones ? 32'hFFFF_FFFF : rf[reg_sel];

    reg_dump_engine #(.DUMP_LIMIT(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy),
        .done      (done),
        .stopped   (stopped)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // rmode: 0 always ready, 1 toggling, 2 random. Returns at a negedge with the engine in IDLE.
    task automatic run_frame(input logic [31:0] pc, input logic [31:0] instr, input int rmode,
                             input bit hold, input int abort_tag);
        logic [31:0] exp_q [$];
        int          n = 0;
        bit          fin = 0;
        bit          aborted = 0;
        bit          prev_stall = 0;
        logic [31:0] pd = 32'd0;
        logic [5:0]  pt = 6'd0;
        exp_q.push_back(pc);
        exp_q.push_back(instr);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(i == 0 ? 32'h0 : (force_ones ? 32'hFFFF_FFFF : rf[i]));
        end
        pc_in    = pc;
        instr_in = instr;
        start    = 1'b1;
        while (!fin) begin
            @(negedge clk);
            n++;
            if (!hold) start = 1'b0;
            pc_in    = $urandom;
            instr_in = $urandom;
            if (n == 1) check("busy_in_frame", 32'(busy), 32'd1);
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", out_data, pd);
                check("stall_tag", 32'(out_tag), 32'(pt));
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = n[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (done) begin
                fin = 1;
                check("word_count", 32'(34 - exp_q.size()), 32'd34);
                if (rmode == 0) check("done_cycle", 32'(n), 32'd67);
            end else if (n > 600) begin
                fin = 1;
                check("timeout", 32'd0, 32'd1);
            end else if (abort_tag >= 0 && out_valid && int'(out_tag) == abort_tag) begin
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                check("abort_valid", 32'(out_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_reg_sel", 32'(reg_sel), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                fin = 1;
                aborted = 1;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'd1, 32'd0);
                end else begin
                    check("tag", 32'(out_tag), 32'(34 - exp_q.size()));
                    check("data", out_data, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pt = out_tag;
        end
        if (!aborted) begin
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_reg_sel", 32'(reg_sel), 32'd31);
        end
    endtask

    initial begin
        force_ones = 1'b0;
        pc_in      = 32'd0;
        instr_in   = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stopped", 32'(stopped), 32'd0);
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        check("rst_data", out_data, 32'd0);

        // Directed frame, then the same frame under a 1/0 ready toggle, which reaches the limit.
        run_frame(32'h0000_0040, 32'h0050_0093, 0, 1'b0, -1);
        check("stopped_after_1", 32'(stopped), 32'd0);
        run_frame(32'h0000_0040, 32'h0050_0093, 1, 1'b0, -1);
        check("stopped_after_2", 32'(stopped), 32'd1);
        start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("ignored_busy", 32'(busy), 32'd0);
            check("ignored_valid", 32'(out_valid), 32'd0);
        end
        start = 1'b0;

        // Start held high: back-to-back frames, each starting in the cycle after IDLE.
        do_reset();
        run_frame(32'h1234_5678, 32'hDEAD_BEEF, 0, 1'b1, -1);
        run_frame(32'h1234_5678, 32'hDEAD_BEEF, 0, 1'b1, -1);
        start = 1'b0;
        check("hold_stopped", 32'(stopped), 32'd1);

        // Reset mid-frame at tag 17, then an immediate full frame.
        do_reset();
        run_frame(32'hCAFE_0000, 32'h0000_0013, 2, 1'b0, 17);
        run_frame(32'hCAFE_0004, 32'h0000_0033, 0, 1'b0, -1);

        // Register file stuck at all ones, x0 still reads as zero.
        do_reset();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        force_ones = 1'b1;
        run_frame(32'h0000_1000, 32'h0000_0001, 2, 1'b0, -1);
        force_ones = 1'b0;

        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            run_frame($urandom, $urandom, int'($urandom_range(0, 2)), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_engine.md
REG_DUMP_ENGINE -- requirements
Module: reg_dump_engine

Interface
REQ-001 The block SHALL take parameter DUMP_LIMIT, default 1000, the number of completed frames after which the engine stops.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: dump request, sampled in IDLE only.
REQ-005 The block SHALL have port pc_in, input, 32 bits: CPU program counter, snapshotted at start.
REQ-006 The block SHALL have port instr_in, input, 32 bits: current instruction, snapshotted at start.
REQ-007 The block SHALL have port reg_sel, output, 5 bits: registered register-file read select driven into the CPU.
REQ-008 The block SHALL have port reg_data, input, 32 bits: combinational register-file read data for reg_sel, valid in the same cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: output word valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-011 The block SHALL have port out_data, output, 32 bits: output word.
REQ-012 The block SHALL have port out_tag, output, 6 bits: word index within the frame, 0 to 33.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-015 The block SHALL have port stopped, output, 1 bit: sticky flag set once DUMP_LIMIT frames have completed.

Function
REQ-016 The FSM SHALL have states IDLE, SEND_PC, SEND_INSTR, FETCH, SEND_REG and DONE.
REQ-017 The FSM SHALL leave IDLE only when start=1 and stopped=0, latching pc_in and instr_in in that same edge and moving to SEND_PC; start is ignored in every other state and whenever stopped=1.
REQ-018 In SEND_PC the block SHALL hold out_valid=1, out_data=latched PC, out_tag=0, and move to SEND_INSTR on the edge where out_ready=1.
REQ-019 In SEND_INSTR the block SHALL hold out_valid=1, out_data=latched instruction, out_tag=1; on the edge where out_ready=1 it SHALL load reg_sel=0 and move to FETCH.
REQ-020 In FETCH the block SHALL hold out_valid=0; at the end of the cycle it SHALL capture reg_data into out_data and move to SEND_REG.
REQ-021 The captured word for reg_sel=0 SHALL be forced to 32'h0, regardless of reg_data.
REQ-022 In SEND_REG the block SHALL hold out_valid=1 and out_tag=reg_sel+2.
REQ-023 On the edge where out_ready=1 in SEND_REG: if reg_sel=31 the FSM SHALL move to DONE; otherwise it SHALL increment reg_sel and move to FETCH.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_tag SHALL remain stable, and out_valid SHALL not drop.
REQ-025 In DONE the block SHALL assert done for exactly 1 cycle, increment frame_cnt (16 bits), and return to IDLE.
REQ-026 If frame_cnt+1 equals DUMP_LIMIT in DONE, the block SHALL set stopped in the same edge.
REQ-027 reg_sel SHALL change only on the SEND_INSTR exit edge and the SEND_REG exit edge, and SHALL hold its value in IDLE.
REQ-028 Minimum frame length with out_ready tied to 1 SHALL be 67 cycles after the start edge: 2 header cycles, 32 x (FETCH + SEND_REG), then 1 DONE cycle.
REQ-029 Exactly 34 handshakes SHALL occur per frame; there is no abort path other than reset.

Reset
REQ-030 With rstn=0 at a rising edge, the block SHALL enter IDLE and clear reg_sel, out_data, out_tag, out_valid, done, busy, stopped, frame_cnt and the PC/instruction latches to 0.
REQ-031 A reset mid-frame SHALL discard the frame with no done pulse; the first cycle after rstn returns to 1 SHALL accept a new start.

Verification
REQ-032 Scenario: pc_in=32'h0000_0040, instr_in=32'h0050_0093, reg model rf[i]=32'h1000_0000+i, out_ready=1, 1-cycle start -> 34 words in order: tag0=00000040, tag1=00500093, tag2=00000000, tag3=10000001 ... tag33=1000001F; done rises 67 cycles after start.
REQ-033 Scenario: same frame with out_ready toggling 1/0 every cycle -> identical word sequence, no word dropped or duplicated, out_data stable while stalled.
REQ-034 Scenario: start held high through the whole frame -> exactly one frame, then a second frame begins on the cycle after done.
REQ-035 Scenario: rstn=0 for 1 cycle at tag=17 -> out_valid=0, busy=0 and reg_sel=0 next cycle, no done pulse, and the next start yields a full 34-word frame.
REQ-036 Scenario: DUMP_LIMIT=2, three starts -> two frames, stopped=1 with the second done, third start ignored, busy stays 0.
REQ-037 Scenario: reg_data forced to FFFFFFFF -> tag2 word=00000000, tags 3-33=FFFFFFFF.
